// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128/192/256 key schedule, one word per clock into a round-key buffer
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

module key_expansion_seq #(
    parameter int MAX_NR = 14,
    parameter bit RD_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         rk_valid,
    output logic [3:0]   nr,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data
);
    localparam int NW = 4 * (MAX_NR + 1);
    localparam int AW = $clog2(NW);
    typedef enum logic {IDLE, EXPAND} state_t;
    state_t state;
    logic [31:0] w [NW];
    logic [AW-1:0] i;
    logic [3:0] nk;
    logic [2:0] cnt;
    logic [7:0] rcon;
    logic [31:0] prev, back, sub_in, sub_out, next_w;
    logic [127:0] rd_comb;
    logic load;
    assign load = state == IDLE && start && key_len != 2'b11;
    assign prev = w[i - AW'(1)];
    assign back = w[i - AW'(nk)];
    assign sub_in = (cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
    end
    assign next_w = back ^ ((cnt == 3'd0) ? sub_out ^ {rcon, 24'h0} :
                            (nk == 4'd8 && cnt == 3'd4) ? sub_out : prev);
    always_ff @(posedge clk) begin
        if (load)
            for (int k = 0; k < 8; k++) w[k] <= key[255 - 32*k -: 32];
        else if (state == EXPAND)
            w[i] <= next_w;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            nr       <= 4'd0;
            nk       <= 4'd4;
            i        <= '0;
            cnt      <= 3'd0;
            rcon     <= 8'h01;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (start && key_len == 2'b11) begin
                    err      <= 1'b1;
                    rk_valid <= 1'b0;
                end else if (start) begin
                    nk       <= 4'd4 + {1'b0, key_len, 1'b0};
                    nr       <= 4'd10 + {1'b0, key_len, 1'b0};
                    i        <= AW'(4'd4 + {1'b0, key_len, 1'b0});
                    cnt      <= 3'd0;
                    rcon     <= 8'h01;
                    rk_valid <= 1'b0;
                    busy     <= 1'b1;
                    state    <= EXPAND;
                end
            end else begin
                i   <= i + AW'(1);
                cnt <= ({1'b0, cnt} == nk - 4'd1) ? 3'd0 : cnt + 3'd1;
                if (cnt == 3'd0)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                if (i == AW'({nr, 2'b11})) begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rk_valid <= 1'b1;
                    state    <= IDLE;
                end
            end
        end
    end
    assign rd_comb = (rk_rd_idx > nr) ? '0 :
        {w[{rk_rd_idx, 2'b00}], w[{rk_rd_idx, 2'b01}], w[{rk_rd_idx, 2'b10}], w[{rk_rd_idx, 2'b11}]};
    if (RD_REG) begin : g_rd_reg
        always_ff @(posedge clk) rk_rd_data <= !rst_n ? '0 : rd_comb;
    end else begin : g_rd_comb
        assign rk_rd_data = rd_comb;
    end
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: directed FIPS-197 vectors for the sequential AES key scheduler
module tb_key_expansion_seq;
    logic clk = 1'b0;
    logic rst_n, start, busy, done, err, rk_valid;
    logic [1:0] key_len;
    logic [255:0] key;
    logic [3:0] nr, rk_rd_idx;
    logic [127:0] rk_rd_data;
    int total = 0;
    int bad = 0;
    int lat;
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A128_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A128_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A128_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A192_RK0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] A192_RK1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] A192_RK12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] A256_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] A256_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] A256_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_expansion_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .done(done), .err(err), .rk_valid(rk_valid), .nr(nr),
        .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] len, input logic [255:0] k, input string tag);
        start = 1'b1;
        key_len = len;
        key = k;
        @(negedge clk);
        start = 1'b0;
        key_len = 2'b11;
        key = ~k;
        chk({tag, "_start"}, {busy, rk_valid, done}, 3'b100);
    endtask

    task automatic wait_done(input int inj, output int n_done);
        n_done = 0;
        for (int n = 1; n <= 80 && n_done == 0; n++) begin
            @(negedge clk);
            if (done) n_done = n;
            start = (inj == 1 && n == 10);
            if (inj == 1 && n == 10) begin
                key_len = 2'b00;
                key = K128;
            end
            rst_n = !(inj == 2 && n >= 20 && n < 23);
        end
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rk_rd_idx = idx;
        @(negedge clk);
        chk(tag, rk_rd_data, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        key_len = 2'b00;
        key = '0;
        rk_rd_idx = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {busy, done, err, rk_valid}, 4'b0000);
        chk("rst_nr", nr, 4'd0);
        chk("rst_rd", rk_rd_data, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        launch(2'b00, K128, "a128");
        wait_done(0, lat);
        chk("a128_latency", lat, 40);
        chk("a128_done_flags", {busy, rk_valid, nr}, {1'b0, 1'b1, 4'd10});
        @(negedge clk);
        chk("a128_done_pulse", done, 1'b0);
        rd(4'd0, A128_RK0, "a128_rk0");
        rd(4'd1, A128_RK1, "a128_rk1");
        rd(4'd10, A128_RK10, "a128_rk10");
        rd(4'd11, 128'h0, "a128_idx11");
        rd(4'd15, 128'h0, "a128_idx15");
        start = 1'b1;
        key_len = 2'b11;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", {err, busy, rk_valid, nr}, {1'b1, 1'b0, 1'b0, 4'd10});
        @(negedge clk);
        chk("err_one_cycle", {err, busy}, 2'b00);
        launch(2'b10, K256, "a256");
        wait_done(0, lat);
        chk("a256_latency", lat, 52);
        chk("a256_done_flags", {busy, rk_valid, nr}, {1'b0, 1'b1, 4'd14});
        rd(4'd0, A256_RK0, "a256_rk0");
        rd(4'd3, A256_RK3, "a256_rk3");
        rd(4'd14, A256_RK14, "a256_rk14");
        launch(2'b10, K256, "busy");
        wait_done(1, lat);
        chk("busy_latency", lat, 52);
        chk("busy_nr", {rk_valid, nr}, {1'b1, 4'd14});
        rd(4'd14, A256_RK14, "busy_rk14");
        rd(4'd3, A256_RK3, "busy_rk3");
        launch(2'b00, K128, "b2b128");
        wait_done(0, lat);
        chk("b2b128_latency", lat, 40);
        launch(2'b01, K192, "b2b192");
        wait_done(0, lat);
        chk("a192_latency", lat, 46);
        chk("a192_done_flags", {busy, rk_valid, nr}, {1'b0, 1'b1, 4'd12});
        rd(4'd12, A192_RK12, "a192_rk12");
        rd(4'd1, A192_RK1, "a192_rk1");
        rd(4'd0, A192_RK0, "a192_rk0");
        rk_rd_idx = 4'd10;
        @(negedge clk);
        chk("a192_rk10_not_a128", rk_rd_data == A128_RK10, 1'b0);
        launch(2'b10, K256, "rst");
        wait_done(2, lat);
        chk("rst_no_done", lat, 0);
        chk("rst_abort_flags", {busy, rk_valid, done, nr}, 7'b0);
        launch(2'b00, K128, "fresh");
        wait_done(0, lat);
        chk("fresh_latency", lat, 40);
        rd(4'd10, A128_RK10, "fresh_rk10");
        rd(4'd1, A128_RK1, "fresh_rk1");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, bad);
        $finish;
    end
endmodule
